// File: rtl/reset_sequencer.sv
// reset_sequencer: orders reset release for clock/DDR/Ethernet bring-up.
// Holds all downstream resets, waits for PLL lock, releases the DDR
// controller, waits for calibration (bounded timeout with retries), then
// releases the Ethernet datapath and the application with fixed gaps.
//
// Ports:
//   clk             single clock, all logic on posedge
//   hardware_rst_n  synchronous active-low block reset
//   software_rst    active-high restart request (synchronous to clk)
//   pll_locked      PLL lock, asynchronous (2-flop synchronized)
//   ddr_calib_done  DDR calibration done, asynchronous (2-flop synchronized)
//   ddr_rst         active-high DDR controller reset
//   eth_rst         active-high Ethernet datapath reset
//   app_rst         active-high application reset
//   seq_done        high while the sequence is complete (RUN)
//   calib_fail      high while latched in FAULT
//   retry_cnt       calibration timeouts since last hardware/software reset
module reset_sequencer #(
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned GAP_CYCLES    = 8,
    parameter int unsigned CALIB_TIMEOUT = 1000000,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned CNT_W         = 20
) (
    input  logic       clk,
    input  logic       hardware_rst_n,
    input  logic       software_rst,
    input  logic       pll_locked,
    input  logic       ddr_calib_done,
    output logic       ddr_rst,
    output logic       eth_rst,
    output logic       app_rst,
    output logic       seq_done,
    output logic       calib_fail,
    output logic [1:0] retry_cnt
);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(CALIB_TIMEOUT - 1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_WAIT_CAL,
        S_GAP_ETH,
        S_GAP_APP,
        S_RUN,
        S_FAULT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       retry_nxt;

    logic lock_meta;
    logic lock_s;
    logic cal_meta;
    logic cal_s;

    // Two-flop synchronizers for the asynchronous status inputs
    always_ff @(posedge clk) begin
        if (!hardware_rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            cal_meta  <= 1'b0;
            cal_s     <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
            cal_meta  <= ddr_calib_done;
            cal_s     <= cal_meta;
        end
    end

    // Next-state, retry and counter decisions
    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;

        if (software_rst) begin
            // Restart request overrides every other transition
            state_nxt = S_HOLD;
            retry_nxt = 2'd0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) state_nxt = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (lock_s) state_nxt = S_WAIT_CAL;
                end
                S_WAIT_CAL: begin
                    // Lock loss first, then calibration success, then timeout
                    if (!lock_s) begin
                        state_nxt = S_HOLD;
                    end else if (cal_s) begin
                        state_nxt = S_GAP_ETH;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (retry_cnt < RETRY_LIMIT) begin
                            retry_nxt = retry_cnt + 2'd1;
                            state_nxt = S_HOLD;
                        end else begin
                            state_nxt = S_FAULT;
                        end
                    end
                end
                S_GAP_ETH: begin
                    if (!lock_s)                state_nxt = S_HOLD;
                    else if (cnt == GAP_LAST)   state_nxt = S_GAP_APP;
                end
                S_GAP_APP: begin
                    if (!lock_s)                state_nxt = S_HOLD;
                    else if (cnt == GAP_LAST)   state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (!lock_s || !cal_s) state_nxt = S_HOLD;
                end
                S_FAULT: begin
                    state_nxt = S_FAULT;
                end
                default: begin
                    state_nxt = S_HOLD;
                end
            endcase
        end

        // Counter restarts on every state entry and only runs in timed states
        cnt_nxt = '0;
        if (!software_rst && state_nxt == state) begin
            case (state)
                S_HOLD, S_WAIT_CAL, S_GAP_ETH, S_GAP_APP: cnt_nxt = cnt + CNT_W'(1);
                default:                                  cnt_nxt = '0;
            endcase
        end
    end

    // State, counter and outputs; outputs decoded from the next state so
    // they switch on the same edge as the state itself
    always_ff @(posedge clk) begin
        if (!hardware_rst_n) begin
            state      <= S_HOLD;
            cnt        <= '0;
            retry_cnt  <= 2'd0;
            ddr_rst    <= 1'b1;
            eth_rst    <= 1'b1;
            app_rst    <= 1'b1;
            seq_done   <= 1'b0;
            calib_fail <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            retry_cnt  <= retry_nxt;
            ddr_rst    <= !(state_nxt == S_WAIT_CAL || state_nxt == S_GAP_ETH ||
                            state_nxt == S_GAP_APP  || state_nxt == S_RUN);
            eth_rst    <= !(state_nxt == S_GAP_APP || state_nxt == S_RUN);
            app_rst    <= (state_nxt != S_RUN);
            seq_done   <= (state_nxt == S_RUN);
            calib_fail <= (state_nxt == S_FAULT);
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scenarios plus randomized stimulus, checked
// every cycle against a phase/elapsed-time reference model.
module tb_reset_sequencer;

    localparam int unsigned HOLD    = 4;
    localparam int unsigned GAP     = 2;
    localparam int unsigned TIMEOUT = 10;
    localparam int unsigned RETRIES = 2;

    logic       clk = 1'b0;
    logic       hardware_rst_n = 1'b0;
    logic       software_rst = 1'b0;
    logic       pll_locked = 1'b0;
    logic       ddr_calib_done = 1'b0;
    logic       ddr_rst;
    logic       eth_rst;
    logic       app_rst;
    logic       seq_done;
    logic       calib_fail;
    logic [1:0] retry_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    string      m_phase = "hold";
    int         m_age = 0;
    int         m_tries = 0;
    logic [1:0] m_lk = 2'b00;
    logic [1:0] m_cl = 2'b00;

    reset_sequencer #(
        .HOLD_CYCLES  (HOLD),
        .GAP_CYCLES   (GAP),
        .CALIB_TIMEOUT(TIMEOUT),
        .MAX_RETRIES  (RETRIES),
        .CNT_W        (20)
    ) dut (
        .clk           (clk),
        .hardware_rst_n(hardware_rst_n),
        .software_rst  (software_rst),
        .pll_locked    (pll_locked),
        .ddr_calib_done(ddr_calib_done),
        .ddr_rst       (ddr_rst),
        .eth_rst       (eth_rst),
        .app_rst       (app_rst),
        .seq_done      (seq_done),
        .calib_fail    (calib_fail),
        .retry_cnt     (retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic enter(input string ph);
        m_phase = ph;
        m_age   = 0;
    endtask

    // One clock edge of the reference: phases last a fixed number of edges,
    // status inputs reach the decision logic two edges after being sampled
    task automatic model_step(input logic hw, input logic sw, input logic lk, input logic cl);
        logic lk_seen;
        logic cl_seen;
        if (!hw) begin
            m_phase = "hold";
            m_age   = 0;
            m_tries = 0;
            m_lk    = 2'b00;
            m_cl    = 2'b00;
            return;
        end
        lk_seen = m_lk[1];
        cl_seen = m_cl[1];
        m_lk    = {m_lk[0], lk};
        m_cl    = {m_cl[0], cl};
        m_age   = m_age + 1;
        if (sw) begin
            enter("hold");
            m_tries = 0;
        end else if (m_phase == "hold") begin
            if (m_age == int'(HOLD)) enter("wait_lock");
        end else if (m_phase == "wait_lock") begin
            if (lk_seen) enter("wait_cal");
        end else if (m_phase == "wait_cal") begin
            if (!lk_seen)                 enter("hold");
            else if (cl_seen)             enter("gap_eth");
            else if (m_age == int'(TIMEOUT)) begin
                if (m_tries < int'(RETRIES)) begin
                    m_tries = m_tries + 1;
                    enter("hold");
                end else begin
                    enter("fault");
                end
            end
        end else if (m_phase == "gap_eth") begin
            if (!lk_seen)                 enter("hold");
            else if (m_age == int'(GAP))  enter("gap_app");
        end else if (m_phase == "gap_app") begin
            if (!lk_seen)                 enter("hold");
            else if (m_age == int'(GAP))  enter("run");
        end else if (m_phase == "run") begin
            if (!lk_seen || !cl_seen)     enter("hold");
        end
    endtask

    task automatic check_model();
        logic ddr_on;
        ddr_on = (m_phase == "wait_cal" || m_phase == "gap_eth" ||
                  m_phase == "gap_app"  || m_phase == "run");
        check("ddr_rst",    32'(ddr_rst),    32'(!ddr_on));
        check("eth_rst",    32'(eth_rst),    32'(!(m_phase == "gap_app" || m_phase == "run")));
        check("app_rst",    32'(app_rst),    32'(m_phase != "run"));
        check("seq_done",   32'(seq_done),   32'(m_phase == "run"));
        check("calib_fail", 32'(calib_fail), 32'(m_phase == "fault"));
        check("retry_cnt",  32'(retry_cnt),  32'(m_tries));
    endtask

    // Apply inputs for the coming edge, advance model, check after the edge
    task automatic tick(input logic hw, input logic sw, input logic lk, input logic cl);
        hardware_rst_n = hw;
        software_rst   = sw;
        pll_locked     = lk;
        ddr_calib_done = cl;
        @(posedge clk);
        model_step(hw, sw, lk, cl);
        #1;
        check_model();
    endtask

    initial begin
        logic hw_r;
        logic sw_r;
        logic lk_r;
        logic cl_r;

        // Reset state
        repeat (3) tick(1'b0, 1'b0, 1'b1, 1'b0);
        check("rst_ddr", 32'(ddr_rst), 32'd1);
        check("rst_done", 32'(seq_done), 32'd0);

        // Nominal bring-up: ddr_rst falls at edge 5, calib 3 cycles later
        for (int e = 1; e <= 20; e++) begin
            tick(1'b1, 1'b0, 1'b1, (e >= 8) ? 1'b1 : 1'b0);
            if (e == 4)  check("nom_ddr_e4", 32'(ddr_rst), 32'd1);
            if (e == 5)  check("nom_ddr_e5", 32'(ddr_rst), 32'd0);
            if (e == 11) check("nom_eth_e11", 32'(eth_rst), 32'd1);
            if (e == 12) check("nom_eth_e12", 32'(eth_rst), 32'd0);
            if (e == 13) check("nom_done_e13", 32'(seq_done), 32'd0);
            if (e == 14) check("nom_done_e14", 32'(seq_done), 32'd1);
        end
        check("nom_retry", 32'(retry_cnt), 32'd0);

        // Single timeout, second attempt succeeds
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 40 && retry_cnt == 2'd0; i++) tick(1'b1, 1'b0, 1'b1, 1'b0);
        check("to_retry", 32'(retry_cnt), 32'd1);
        check("to_ddr", 32'(ddr_rst), 32'd1);
        repeat (30) tick(1'b1, 1'b0, 1'b1, 1'b1);
        check("to_run", 32'(seq_done), 32'd1);
        check("to_retry_run", 32'(retry_cnt), 32'd1);

        // Fault after three attempts, then software restart
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (100) tick(1'b1, 1'b0, 1'b1, 1'b0);
        check("flt_fail", 32'(calib_fail), 32'd1);
        check("flt_retry", 32'(retry_cnt), 32'd2);
        check("flt_app", 32'(app_rst), 32'd1);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        check("flt_clr_fail", 32'(calib_fail), 32'd0);
        check("flt_clr_retry", 32'(retry_cnt), 32'd0);

        // Loss of lock in RUN with one retry recorded
        repeat (16) tick(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (30) tick(1'b1, 1'b0, 1'b1, 1'b1);
        check("lol_run", 32'(seq_done), 32'd1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("lol_e2_done", 32'(seq_done), 32'd1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        check("lol_e3_done", 32'(seq_done), 32'd0);
        check("lol_e3_ddr", 32'(ddr_rst), 32'd1);
        repeat (30) tick(1'b1, 1'b0, 1'b1, 1'b1);
        check("lol_rerun", 32'(seq_done), 32'd1);
        check("lol_retry", 32'(retry_cnt), 32'd1);

        // Software reset in the same cycle calibration is seen
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20 && ddr_rst == 1'b1; i++) tick(1'b1, 1'b0, 1'b1, 1'b0);
        check("pri_in_cal", 32'(ddr_rst), 32'd0);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        check("pri_ddr", 32'(ddr_rst), 32'd1);
        for (int i = 0; i < int'(HOLD); i++) begin
            tick(1'b1, 1'b0, 1'b1, 1'b1);
            check("pri_eth_held", 32'(eth_rst), 32'd1);
        end
        repeat (20) tick(1'b1, 1'b0, 1'b1, 1'b1);

        // Hardware reset wins over software reset
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        check("hw_ddr", 32'(ddr_rst), 32'd1);
        check("hw_eth", 32'(eth_rst), 32'd1);
        check("hw_app", 32'(app_rst), 32'd1);
        check("hw_done", 32'(seq_done), 32'd0);
        check("hw_fail", 32'(calib_fail), 32'd0);
        check("hw_retry", 32'(retry_cnt), 32'd0);

        // Randomized stimulus against the model
        lk_r = 1'b1;
        cl_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            hw_r = ($urandom_range(0, 399) != 0);
            sw_r = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 79) == 0) lk_r = ~lk_r;
            if ($urandom_range(0, 11) == 0) cl_r = ~cl_r;
            tick(hw_r, sw_r, lk_r, cl_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Sequences reset release for the board's clock/DDR/Ethernet bring-up from a single internal clock. It holds all downstream resets, waits for PLL lock, releases the DDR controller, waits for DDR calibration with a bounded timeout and retry, then releases the Ethernet datapath and application logic in order with fixed gaps. It sits between the top-level reset sources (hardware reset, software reset register) and the per-subsystem reset inputs. It replaces direct use of a single combined internal reset.

## Interface
Parameters:
- HOLD_CYCLES, 16, cycles all resets stay asserted in HOLD (≥1)
- GAP_CYCLES, 8, cycles between successive releases after calibration (≥1)
- CALIB_TIMEOUT, 1000000, cycles allowed in WAIT_CAL before timeout (≥1)
- MAX_RETRIES, 3, timeouts tolerated before FAULT (0..3)
- CNT_W, 20, counter width; must hold max(HOLD_CYCLES, GAP_CYCLES, CALIB_TIMEOUT)

Ports:
- clk  in  1  single clock; all logic on posedge
- hardware_rst_n  in  1  synchronous, active-low block reset
- software_rst  in  1  active-high restart request, synchronous to clk, sampled every cycle
- pll_locked  in  1  PLL lock, asynchronous, 2-flop synchronized internally
- ddr_calib_done  in  1  DDR calibration complete, asynchronous, 2-flop synchronized internally
- ddr_rst  out  1  active-high DDR controller reset
- eth_rst  out  1  active-high Ethernet datapath reset
- app_rst  out  1  active-high application reset
- seq_done  out  1  high in RUN only
- calib_fail  out  1  high in FAULT only
- retry_cnt  out  2  calibration timeouts taken since last hardware/software reset

## Operation
- States: HOLD, WAIT_LOCK, WAIT_CAL, GAP_ETH, GAP_APP, RUN, FAULT. One shared counter `cnt`, cleared on every state entry.
- HOLD: all resets asserted; after HOLD_CYCLES cycles -> WAIT_LOCK.
- WAIT_LOCK: when lock_s=1 -> WAIT_CAL.
- WAIT_CAL: if cal_s=1 -> GAP_ETH. Else if cnt reaches CALIB_TIMEOUT-1: if retry_cnt<MAX_RETRIES, increment retry_cnt and go to HOLD; else go to FAULT. cal_s has priority over timeout in the same cycle.
- GAP_ETH: after GAP_CYCLES cycles -> GAP_APP.
- GAP_APP: after GAP_CYCLES cycles -> RUN.
- RUN: lock_s=0 or cal_s=0 -> HOLD; retry_cnt unchanged.
- FAULT: all resets asserted, calib_fail=1; leaves only on software_rst.
- software_rst=1 in any state -> HOLD next edge. Also clears retry_cnt. Takes priority over every other transition. Held high, the block stays in HOLD with cnt cleared.
- Loss of lock_s in WAIT_CAL, GAP_ETH or GAP_APP -> HOLD, retry_cnt unchanged.
- Outputs are registered and decoded from the next state, so they change on the same edge as the state:
  - ddr_rst=0 in WAIT_CAL, GAP_ETH, GAP_APP, RUN
  - eth_rst=0 in GAP_APP, RUN
  - app_rst=0 in RUN
- Release order is always ddr -> eth -> app. Reassertion of all three happens on a single edge.

## Timing
- hardware_rst_n=0 at an edge forces:
  - state=HOLD, cnt=0, retry_cnt=0, synchronizers=0
  - ddr_rst=eth_rst=app_rst=1, seq_done=0, calib_fail=0
  - Takes priority over software_rst. Applying it mid-sequence behaves identically.
- Edge 1 = first edge sampling hardware_rst_n=1. WAIT_LOCK is entered at edge HOLD_CYCLES.
- With lock_s already high, ddr_rst falls at edge HOLD_CYCLES+1.
- Input-to-action latency is 3 edges: an ddr_calib_done or pll_locked change registered at edge c acts at edge c+3.
- Calibration release, with cal_s first high at edge c+2:
  - GAP_ETH entered at c+3
  - eth_rst falls at c+3+GAP_CYCLES
  - app_rst falls and seq_done rises at c+3+2·GAP_CYCLES
- Timeout: exactly CALIB_TIMEOUT cycles in WAIT_CAL. On the following edge ddr_rst=1 and HOLD or FAULT is entered.
- software_rst high at edge s: all resets asserted and seq_done=0 at edge s+1.

## Test plan
Bench parameters: HOLD_CYCLES=4, GAP_CYCLES=2, CALIB_TIMEOUT=10, MAX_RETRIES=2.
- Nominal bring-up:
  - Stimulus: pll_locked high throughout; ddr_calib_done rises 3 cycles after ddr_rst falls.
  - Response: ddr_rst falls at edge 5; eth_rst 2 edges after GAP_ETH entry; app_rst and seq_done 2 edges later; retry_cnt=0.
- Single timeout:
  - Stimulus: ddr_calib_done low for the first attempt, high during the second.
  - Response: ddr_rst reasserts after 10 cycles low; retry_cnt=1; second attempt completes to RUN.
- Fault:
  - Stimulus: ddr_calib_done never rises.
  - Response: three attempts; retry_cnt=2; then FAULT with calib_fail=1 and all resets high indefinitely. A one-cycle software_rst clears calib_fail and retry_cnt and restarts HOLD.
- Loss of lock in RUN:
  - Stimulus: pll_locked drops.
  - Response: all resets high and seq_done=0 3 edges later; relock re-sequences to RUN; retry_cnt unchanged.
- Priority:
  - Stimulus: software_rst asserted in the same cycle cal_s is seen in WAIT_CAL.
  - Response: HOLD is taken; eth_rst never released.
- Hardware reset priority:
  - Stimulus: hardware_rst_n low with software_rst high.
  - Response: reset values exactly as listed in Timing.
